// File: rtl/puf_ecc_pkg.sv
// Shared types and helper functions for the PUF SECDED conditioning engine.
`timescale 1ns/1ps
package puf_ecc_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL   = 2'd0,
    OP_PROVISION = 2'd1,
    OP_CORRECT   = 2'd2,
    OP_CLEAR     = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_CORRECTED = 2'd1,
    ST_UNCORR    = 2'd2,
    ST_REJECTED  = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Smallest r with 2^r >= width + r + 1.
  function automatic int unsigned secded_r(input int unsigned width);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < width + r + 1) r++;
    return r;
  endfunction

  // Code position of data bit d: d-th non-power-of-two position from 3 upward.
  function automatic int unsigned data_pos(input int unsigned d);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d) return p;
        cnt++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/puf_ecc_engine_secded_chunk.sv
// Combinational extended-Hamming encoder/decoder for one CHUNK_W-bit codeword.
`timescale 1ns/1ps
module secded_chunk import puf_ecc_pkg::*; #(
  parameter int unsigned CHUNK_W = 16,
  localparam int unsigned R      = secded_r(CHUNK_W),
  localparam int unsigned PAR_W  = R + 1
) (
  input  logic [CHUNK_W-1:0] data,
  input  logic [PAR_W-1:0]   stored_par,
  output logic [PAR_W-1:0]   enc_parity,
  output logic [CHUNK_W-1:0] corr_data,
  output logic               single_err,
  output logic               double_err
);

  localparam int unsigned NPOS = CHUNK_W + R;

  logic [R-1:0] chk;
  logic [R-1:0] syn;
  logic         par_mis;

  always_comb begin
    chk = '0;
    for (int unsigned d = 0; d < CHUNK_W; d++) begin
      for (int unsigned k = 0; k < R; k++) begin
        if (((data_pos(d) >> k) & 32'd1) != 0) chk[k] = chk[k] ^ data[d];
      end
    end
    enc_parity = {(^data) ^ (^chk), chk};

    // Overall parity over received data plus all stored check/parity bits.
    syn        = chk ^ stored_par[R-1:0];
    par_mis    = (^data) ^ (^stored_par);
    single_err = par_mis && (32'(syn) <= NPOS);
    double_err = (!par_mis && (syn != '0)) || (par_mis && (32'(syn) > NPOS));

    corr_data = data;
    for (int unsigned d = 0; d < CHUNK_W; d++) begin
      if (single_err && (32'(syn) == data_pos(d))) corr_data[d] = ~data[d];
    end
  end

endmodule

// File: rtl/puf_ecc_engine.sv
// PUF signature conditioning engine: provisions SECDED helper parity per IP slot
// and repairs noisy re-reads LANES chunks per cycle.
`timescale 1ns/1ps
module puf_ecc_engine import puf_ecc_pkg::*; #(
  parameter int unsigned PUF_SIG_LENGTH = 256,
  parameter int unsigned IPID_N         = 16,
  parameter int unsigned CHUNK_W        = 16,
  parameter int unsigned LANES          = 1,
  localparam int unsigned NCH           = PUF_SIG_LENGTH / CHUNK_W,
  localparam int unsigned CW            = $clog2(NCH + 1),
  localparam int unsigned IPW           = $clog2(IPID_N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [IPW-1:0]            cmd_ipid,
  input  logic [PUF_SIG_LENGTH-1:0] cmd_sig,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [PUF_SIG_LENGTH-1:0] resp_sig,
  output logic [1:0]                resp_status,
  output logic [CW-1:0]             resp_corr_cnt,
  output logic [CW-1:0]             resp_uncorr_cnt,
  output logic [IPID_N-1:0]         prov_mask
);

  localparam int unsigned STEPS  = NCH / LANES;
  localparam int unsigned R      = secded_r(CHUNK_W);
  localparam int unsigned PAR_W  = R + 1;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned CIDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                     state_q, state_d;
  op_t                        op_q, op_d;
  logic [IPW-1:0]             ipid_q, ipid_d;
  logic [NCH-1:0][CHUNK_W-1:0] sig_q, sig_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [CW-1:0]              corr_q, corr_d;
  logic [CW-1:0]              uncorr_q, uncorr_d;
  status_t                    status_q, status_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [IPID_N-1:0]          prov_q, prov_d;

  logic [PAR_W-1:0]           helper_q [IPID_N][NCH];

  logic [CIDX_W-1:0]          lane_idx   [LANES];
  logic [CHUNK_W-1:0]         lane_dout  [LANES];
  logic [PAR_W-1:0]           lane_enc   [LANES];
  logic [LANES-1:0]           lane_single;
  logic [LANES-1:0]           lane_double;
  logic [CW-1:0]              lane_corr, lane_unc;
  logic                       last_step;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = CIDX_W'(32'(step_q) * LANES + l);

    secded_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
      .data       (sig_q[lane_idx[l]]),
      .stored_par (helper_q[ipid_q][lane_idx[l]]),
      .enc_parity (lane_enc[l]),
      .corr_data  (lane_dout[l]),
      .single_err (lane_single[l]),
      .double_err (lane_double[l])
    );
  end

  assign last_step = (32'(step_q) == STEPS - 1);

  // Helper parity is plain storage; validity is tracked solely by prov_mask.
  always_ff @(posedge clk) begin
    if (state_q == S_PROC && op_q == OP_PROVISION) begin
      for (int unsigned l = 0; l < LANES; l++) helper_q[ipid_q][lane_idx[l]] <= lane_enc[l];
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ipid_d       = ipid_q;
    sig_d        = sig_q;
    step_d       = step_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;
    status_d     = status_q;
    resp_valid_d = resp_valid_q;
    prov_d       = prov_q;

    lane_corr = '0;
    lane_unc  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_corr = lane_corr + CW'(lane_single[l]);
      lane_unc  = lane_unc + CW'(lane_double[l]);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = op_t'(cmd_op);
          ipid_d   = cmd_ipid;
          sig_d    = cmd_sig;
          step_d   = '0;
          corr_d   = '0;
          uncorr_d = '0;
          state_d  = S_PROC;
        end
      end
      S_PROC: begin
        step_d = step_q + 1'b1;
        case (op_q)
          OP_PROVISION: begin
            if (last_step) begin
              prov_d[ipid_q] = 1'b1;
              status_d       = ST_OK;
              resp_valid_d   = 1'b1;
              state_d        = S_RESP;
            end
          end
          OP_CORRECT: begin
            if (!prov_q[ipid_q]) begin
              status_d     = ST_REJECTED;
              resp_valid_d = 1'b1;
              state_d      = S_RESP;
            end else begin
              for (int unsigned l = 0; l < LANES; l++) sig_d[lane_idx[l]] = lane_dout[l];
              corr_d   = corr_q + lane_corr;
              uncorr_d = uncorr_q + lane_unc;
              if (last_step) begin
                status_d     = (uncorr_d != '0) ? ST_UNCORR :
                               (corr_d != '0)   ? ST_CORRECTED : ST_OK;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
              end
            end
          end
          OP_CLEAR: begin
            prov_d[ipid_q] = 1'b0;
            status_d       = ST_OK;
            resp_valid_d   = 1'b1;
            state_d        = S_RESP;
          end
          OP_ILLEGAL: begin
            status_d     = ST_REJECTED;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        endcase
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ILLEGAL;
      ipid_q       <= '0;
      sig_q        <= '0;
      step_q       <= '0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      status_q     <= ST_OK;
      resp_valid_q <= 1'b0;
      prov_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ipid_q       <= ipid_d;
      sig_q        <= sig_d;
      step_q       <= step_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      status_q     <= status_d;
      resp_valid_q <= resp_valid_d;
      prov_q       <= prov_d;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_sig        = sig_q;
  assign resp_status     = status_q;
  assign resp_corr_cnt   = corr_q;
  assign resp_uncorr_cnt = uncorr_q;
  assign prov_mask       = prov_q;

endmodule
